// File: rtl/spr_access_ctrl.sv
// ---------------------------------------------------------------------------
// spr_access_ctrl
//
// Initiator-side controller for the special-purpose register (SPR) file.
// Takes mfspr/mtspr requests from the execute stage, decodes the swapped-half
// SPR field, checks legality and privilege, drives one write port and one
// read port of the SPR file, and returns read data or an exception code on a
// registered valid/ready response channel.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   req_valid_i    request present
//   req_ready_o    request accepted this cycle
//   req_wr_i       1 = mtspr, 0 = mfspr
//   req_sprn_i     raw instruction SPR field (halves swapped)
//   req_wdata_i    mtspr source data
//   req_pr_i       MSR[PR], 1 = user mode
//   req_tag_i      opaque tag echoed on the response
//   rsp_valid_o    response present
//   rsp_ready_i    consumer takes the response
//   rsp_rdata_o    SPR value read during EXEC (0 on exception)
//   rsp_tag_o      echoed tag
//   rsp_exc_o      00 ok, 01 illegal SPR, 10 privilege violation
//   spr_wr_o       SPR file write enable (EXEC only)
//   spr_waddr_o    decoded SPR number for the write
//   spr_wd_o       write data
//   spr_raddr_o    decoded SPR number for the read
//   spr_rd_i       combinational read data from the SPR file
//   exc_cnt_o      saturating count of responses with nonzero exception code
// ---------------------------------------------------------------------------
module spr_access_ctrl #(
    parameter int SPR_DEPTH = 10,
    parameter int SPR_WIDTH = 32,
    parameter int TAG_W     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_wr_i,
    input  logic [SPR_DEPTH-1:0] req_sprn_i,
    input  logic [SPR_WIDTH-1:0] req_wdata_i,
    input  logic                 req_pr_i,
    input  logic [TAG_W-1:0]     req_tag_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [SPR_WIDTH-1:0] rsp_rdata_o,
    output logic [TAG_W-1:0]     rsp_tag_o,
    output logic [1:0]           rsp_exc_o,
    output logic                 spr_wr_o,
    output logic [SPR_DEPTH-1:0] spr_waddr_o,
    output logic [SPR_WIDTH-1:0] spr_wd_o,
    output logic [SPR_DEPTH-1:0] spr_raddr_o,
    input  logic [SPR_WIDTH-1:0] spr_rd_i,
    output logic [7:0]           exc_cnt_o
);

    localparam int HALF = SPR_DEPTH / 2;

    localparam logic [1:0] EXC_OK      = 2'b00;
    localparam logic [1:0] EXC_ILLEGAL = 2'b01;
    localparam logic [1:0] EXC_PRIV    = 2'b10;

    // Architected SPR numbers that this file implements.
    localparam logic [SPR_DEPTH-1:0] SPRN_XER   = SPR_DEPTH'(10'd1);
    localparam logic [SPR_DEPTH-1:0] SPRN_LR    = SPR_DEPTH'(10'd8);
    localparam logic [SPR_DEPTH-1:0] SPRN_CTR   = SPR_DEPTH'(10'd9);
    localparam logic [SPR_DEPTH-1:0] SPRN_DEC   = SPR_DEPTH'(10'd22);
    localparam logic [SPR_DEPTH-1:0] SPRN_SRR0  = SPR_DEPTH'(10'd26);
    localparam logic [SPR_DEPTH-1:0] SPRN_SRR1  = SPR_DEPTH'(10'd27);
    localparam logic [SPR_DEPTH-1:0] SPRN_SPRG0 = SPR_DEPTH'(10'd272);
    localparam logic [SPR_DEPTH-1:0] SPRN_SPRG1 = SPR_DEPTH'(10'd273);
    localparam logic [SPR_DEPTH-1:0] SPRN_SPRG2 = SPR_DEPTH'(10'd274);
    localparam logic [SPR_DEPTH-1:0] SPRN_SPRG3 = SPR_DEPTH'(10'd275);
    localparam logic [SPR_DEPTH-1:0] SPRN_PVR   = SPR_DEPTH'(10'd287);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // The instruction encodes the SPR number with its two halves swapped.
    function automatic logic [SPR_DEPTH-1:0] decode_sprn(input logic [SPR_DEPTH-1:0] f);
        return {f[HALF-1:0], f[SPR_DEPTH-1:HALF]};
    endfunction

    function automatic logic is_legal_sprn(input logic [SPR_DEPTH-1:0] n);
        logic legal;
        case (n)
            SPRN_XER, SPRN_LR, SPRN_CTR, SPRN_DEC,
            SPRN_SRR0, SPRN_SRR1,
            SPRN_SPRG0, SPRN_SPRG1, SPRN_SPRG2, SPRN_SPRG3,
            SPRN_PVR: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Exception priority: illegal number, then write to read-only PVR,
    // then privileged SPR (n[4] set) accessed from user mode.
    function automatic logic [1:0] calc_exc(input logic                 wr,
                                            input logic [SPR_DEPTH-1:0] n,
                                            input logic                 pr);
        logic [1:0] exc;
        if (!is_legal_sprn(n)) begin
            exc = EXC_ILLEGAL;
        end else if (wr && (n == SPRN_PVR)) begin
            exc = EXC_ILLEGAL;
        end else if (n[4] && pr) begin
            exc = EXC_PRIV;
        end else begin
            exc = EXC_OK;
        end
        return exc;
    endfunction

    state_e state_q, state_d;

    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [1:0]           exc_q, exc_d;
    logic [SPR_DEPTH-1:0] raddr_q, raddr_d;
    logic [SPR_DEPTH-1:0] waddr_q, waddr_d;
    logic [SPR_WIDTH-1:0] wd_q, wd_d;
    logic                 spr_wr_q, spr_wr_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [SPR_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
    logic [1:0]           rsp_exc_q, rsp_exc_d;
    logic [7:0]           exc_cnt_q, exc_cnt_d;

    logic                 req_ready_s;
    logic                 rsp_hs_s;
    logic                 accept_s;
    logic [SPR_DEPTH-1:0] req_n_s;
    logic [1:0]           req_exc_s;

    assign req_n_s   = decode_sprn(req_sprn_i);
    assign req_exc_s = calc_exc(req_wr_i, req_n_s, req_pr_i);
    assign accept_s  = req_valid_i & req_ready_s;

    // Next-state logic and request/response handshake qualifiers.
    always_comb begin
        state_d     = state_q;
        req_ready_s = 1'b0;
        rsp_hs_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid_i) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // Completing the response frees the slot for a back-to-back request.
                if (rsp_ready_i) begin
                    req_ready_s = 1'b1;
                    rsp_hs_s    = 1'b1;
                    if (req_valid_i) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next values: request latch, SPR port drive, response and counter.
    always_comb begin
        tag_d       = tag_q;
        exc_d       = exc_q;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        wd_d        = wd_q;
        spr_wr_d    = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_exc_d   = rsp_exc_q;
        exc_cnt_d   = exc_cnt_q;

        // Addresses are loaded on acceptance so they are valid throughout
        // EXEC and then simply hold until the next request.
        if (accept_s) begin
            tag_d    = req_tag_i;
            exc_d    = req_exc_s;
            raddr_d  = req_n_s;
            waddr_d  = req_n_s;
            wd_d     = req_wdata_i;
            spr_wr_d = req_wr_i & (req_exc_s == EXC_OK);
        end else begin
            spr_wr_d = 1'b0;
        end

        // The read is combinational, so an mtspr returns the pre-write value.
        if (state_q == ST_EXEC) begin
            rsp_valid_d = 1'b1;
            rsp_tag_d   = tag_q;
            rsp_exc_d   = exc_q;
            if (exc_q == EXC_OK) begin
                rsp_rdata_d = spr_rd_i;
            end else begin
                rsp_rdata_d = {SPR_WIDTH{1'b0}};
            end
        end else if (rsp_hs_s) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end

        if (rsp_hs_s && (rsp_exc_q != EXC_OK) && (exc_cnt_q != 8'hFF)) begin
            exc_cnt_d = exc_cnt_q + 8'd1;
        end else begin
            exc_cnt_d = exc_cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_q       <= {TAG_W{1'b0}};
            exc_q       <= EXC_OK;
            raddr_q     <= {SPR_DEPTH{1'b0}};
            waddr_q     <= {SPR_DEPTH{1'b0}};
            wd_q        <= {SPR_WIDTH{1'b0}};
            spr_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {SPR_WIDTH{1'b0}};
            rsp_tag_q   <= {TAG_W{1'b0}};
            rsp_exc_q   <= EXC_OK;
            exc_cnt_q   <= 8'd0;
        end else begin
            tag_q       <= tag_d;
            exc_q       <= exc_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            wd_q        <= wd_d;
            spr_wr_q    <= spr_wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_exc_q   <= rsp_exc_d;
            exc_cnt_q   <= exc_cnt_d;
        end
    end

    // Reset asserted during EXEC must suppress the write in that very cycle.
    assign spr_wr_o    = spr_wr_q & ~rst_i;
    assign req_ready_o = req_ready_s & ~rst_i;

    assign spr_waddr_o = waddr_q;
    assign spr_raddr_o = raddr_q;
    assign spr_wd_o    = wd_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_tag_o   = rsp_tag_q;
    assign rsp_exc_o   = rsp_exc_q;
    assign exc_cnt_o   = exc_cnt_q;

endmodule

// File: tb/tb_spr_access_ctrl.sv
module tb_spr_access_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [9:0]  req_sprn;
    logic [31:0] req_wdata;
    logic        req_pr;
    logic [3:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [3:0]  rsp_tag;
    logic [1:0]  rsp_exc;
    logic        spr_wr;
    logic [9:0]  spr_waddr;
    logic [31:0] spr_wd;
    logic [9:0]  spr_raddr;
    logic [31:0] spr_rd;
    logic [7:0]  exc_cnt;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    int hs_cnt = 0;

    // Simple SPR file model: 32 entries indexed by the low five bits.
    logic [31:0] spr_mem [32];

    spr_access_ctrl #(.SPR_DEPTH(10), .SPR_WIDTH(32), .TAG_W(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_wr_i    (req_wr),
        .req_sprn_i  (req_sprn),
        .req_wdata_i (req_wdata),
        .req_pr_i    (req_pr),
        .req_tag_i   (req_tag),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_tag_o   (rsp_tag),
        .rsp_exc_o   (rsp_exc),
        .spr_wr_o    (spr_wr),
        .spr_waddr_o (spr_waddr),
        .spr_wd_o    (spr_wd),
        .spr_raddr_o (spr_raddr),
        .spr_rd_i    (spr_rd),
        .exc_cnt_o   (exc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign spr_rd = spr_mem[spr_raddr[4:0]];

    always @(posedge clk) begin
        if (spr_wr) begin
            spr_mem[spr_waddr[4:0]] <= spr_wd;
            wr_pulses <= wr_pulses + 1;
        end
        if (rsp_valid && rsp_ready) begin
            hs_cnt <= hs_cnt + 1;
        end
    end

    typedef struct {
        logic        wr;
        logic [9:0]  f;
        logic [9:0]  n;
        logic [31:0] wdata;
        logic        pr;
        logic [3:0]  tag;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_exc;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one request from IDLE and complete its response immediately.
    task automatic run_vec(input vec_t v);
        int   pulses0;
        logic exp_write;
        exp_write = v.wr && (v.exp_exc == 2'b00);
        pulses0   = wr_pulses;
        req_wr    = v.wr;
        req_sprn  = v.f;
        req_wdata = v.wdata;
        req_pr    = v.pr;
        req_tag   = v.tag;
        req_valid = 1'b1;
        #1;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("exec_raddr", {22'd0, spr_raddr}, {22'd0, v.n});
        chk("exec_spr_wr", {31'd0, spr_wr}, {31'd0, exp_write});
        chk("exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_exc", {30'd0, rsp_exc}, {30'd0, v.exp_exc});
        chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, v.tag});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_dropped", {31'd0, rsp_valid}, 32'd0);
        chk("exc_cnt", {24'd0, exc_cnt}, {24'd0, v.exp_cnt});
        chk("wr_pulses", wr_pulses - pulses0, {31'd0, exp_write});
    endtask

    initial begin
        int   cycles;
        int   hs0;
        int   pulses0;
        logic seen254;
        logic seen255;

        for (int i = 0; i < 32; i++) spr_mem[i] = 32'd0;

        //            wr    f        n        wdata         pr    tag    rdata         exc    cnt
        vecs[0]  = '{1'b1, 10'h100, 10'd8,   32'hDEADBEEF, 1'b0, 4'h3, 32'h00000000, 2'b00, 8'd0};
        vecs[1]  = '{1'b0, 10'h100, 10'd8,   32'h00000000, 1'b0, 4'h4, 32'hDEADBEEF, 2'b00, 8'd0};
        vecs[2]  = '{1'b0, 10'h340, 10'd26,  32'h00000000, 1'b1, 4'h5, 32'h00000000, 2'b10, 8'd1};
        vecs[3]  = '{1'b1, 10'h0A0, 10'd5,   32'h00000011, 1'b0, 4'h6, 32'h00000000, 2'b01, 8'd2};
        vecs[4]  = '{1'b1, 10'h3E8, 10'd287, 32'h00000022, 1'b0, 4'h7, 32'h00000000, 2'b01, 8'd3};
        vecs[5]  = '{1'b1, 10'h208, 10'd272, 32'hCAFE0001, 1'b0, 4'h8, 32'h00000000, 2'b00, 8'd3};
        vecs[6]  = '{1'b0, 10'h208, 10'd272, 32'h00000000, 1'b1, 4'h9, 32'h00000000, 2'b10, 8'd4};
        vecs[7]  = '{1'b0, 10'h208, 10'd272, 32'h00000000, 1'b0, 4'hA, 32'hCAFE0001, 2'b00, 8'd4};
        vecs[8]  = '{1'b1, 10'h020, 10'd1,   32'h00000055, 1'b1, 4'hB, 32'h00000000, 2'b00, 8'd4};
        vecs[9]  = '{1'b0, 10'h020, 10'd1,   32'h00000000, 1'b1, 4'hC, 32'h00000055, 2'b00, 8'd4};
        vecs[10] = '{1'b0, 10'h3E8, 10'd287, 32'h00000000, 1'b0, 4'hD, 32'h00000000, 2'b00, 8'd4};
        vecs[11] = '{1'b1, 10'h360, 10'd27,  32'h00000077, 1'b1, 4'hE, 32'h00000000, 2'b10, 8'd5};
        vecs[12] = '{1'b0, 10'h360, 10'd27,  32'h00000000, 1'b0, 4'hF, 32'h00000000, 2'b00, 8'd5};
        vecs[13] = '{1'b1, 10'h100, 10'd8,   32'h12345678, 1'b1, 4'h0, 32'hDEADBEEF, 2'b00, 8'd5};
        vecs[14] = '{1'b0, 10'h2C0, 10'd22,  32'h00000000, 1'b0, 4'h1, 32'h00000000, 2'b00, 8'd5};
        vecs[15] = '{1'b0, 10'h000, 10'd0,   32'h00000000, 1'b0, 4'h2, 32'h00000000, 2'b01, 8'd6};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_sprn  = 10'd0;
        req_wdata = 32'd0;
        req_pr    = 1'b0;
        req_tag   = 4'd0;
        rsp_ready = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_spr_wr", {31'd0, spr_wr}, 32'd0);
        chk("rst_exc_cnt", {24'd0, exc_cnt}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Table-driven single transactions
        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i]);
        end

        // Response backpressure with a queued request (LR now 0x12345678)
        req_wr = 1'b0; req_sprn = 10'h100; req_pr = 1'b0; req_tag = 4'h1; req_wdata = 32'd0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_sprn = 10'h208; req_tag = 4'h2;
        chk("bp_exec_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata", rsp_rdata, 32'h12345678);
            chk("bp_tag", {28'd0, rsp_tag}, 32'd1);
            chk("bp_exc", {30'd0, rsp_exc}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("b2b_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("b2b_exec_raddr", {22'd0, spr_raddr}, 32'd272);
        @(posedge clk); #1;
        chk("b2b_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_rdata", rsp_rdata, 32'hCAFE0001);
        chk("b2b_tag", {28'd0, rsp_tag}, 32'd2);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("b2b_done", {31'd0, rsp_valid}, 32'd0);

        // Reset during EXEC of mtspr CTR
        req_wr = 1'b1; req_sprn = 10'h120; req_wdata = 32'h00001234; req_pr = 1'b0; req_tag = 4'h3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_exec_wr_armed", {31'd0, spr_wr}, 32'd1);
        pulses0 = wr_pulses;
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_blocked", {31'd0, spr_wr}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_tag", {28'd0, rsp_tag}, 32'd0);
        chk("mid_rst_exc", {30'd0, rsp_exc}, 32'd0);
        chk("mid_rst_waddr", {22'd0, spr_waddr}, 32'd0);
        chk("mid_rst_raddr", {22'd0, spr_raddr}, 32'd0);
        chk("mid_rst_wd", spr_wd, 32'd0);
        chk("mid_rst_spr_wr", {31'd0, spr_wr}, 32'd0);
        chk("mid_rst_exc_cnt", {24'd0, exc_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_no_write", wr_pulses - pulses0, 32'd0);
        run_vec('{1'b0, 10'h120, 10'd9, 32'h00000000, 1'b0, 4'h4, 32'h00000000, 2'b00, 8'd0});

        // Counter saturation: 260 back-to-back illegal requests (n=5)
        req_wr = 1'b0; req_sprn = 10'h0A0; req_pr = 1'b0; req_tag = 4'h5;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        hs0 = hs_cnt;
        cycles = 0;
        seen254 = 1'b0;
        seen255 = 1'b0;
        while ((hs_cnt - hs0 < 260) && (cycles < 2000)) begin
            @(posedge clk); #1;
            cycles++;
            if ((hs_cnt - hs0 == 254) && !seen254) begin
                seen254 = 1'b1;
                chk("sat_cnt_254", {24'd0, exc_cnt}, 32'd254);
            end
            if ((hs_cnt - hs0 == 255) && !seen255) begin
                seen255 = 1'b1;
                chk("sat_cnt_255", {24'd0, exc_cnt}, 32'd255);
            end
        end
        chk("sat_cycles", cycles, 32'd521);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("sat_hold", {24'd0, exc_cnt}, 32'd255);
        chk("sat_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("sat_no_rsp", {31'd0, rsp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spr_access_ctrl.md
# spr_access_ctrl

Initiator-side controller for the special-purpose register file. It accepts mfspr/mtspr requests from the execute stage over a valid/ready handshake and decodes the swapped-half SPR field from the instruction. It checks legality and privilege, drives the register file's write port 0 and read port 0, and returns the read data or an exception code over a valid/ready response channel. It sits between the execute stage and the SPR file, and is the only agent on those two SPR ports.

## Interface
- `SPR_DEPTH`, 10: SPR number width.
- `SPR_WIDTH`, 32: SPR data width.
- `TAG_W`, 4: request tag width.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller accepts the request this cycle.
- `req_wr` in 1: 1 = mtspr, 0 = mfspr.
- `req_sprn` in `SPR_DEPTH`: raw instruction SPR field f[9:0] (halves swapped).
- `req_wdata` in `SPR_WIDTH`: mtspr source data.
- `req_pr` in 1: MSR[PR]; 1 = user mode.
- `req_tag` in `TAG_W`: opaque tag, echoed on the response.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out `SPR_WIDTH`: SPR value read in EXEC.
- `rsp_tag` out `TAG_W`: echoed tag.
- `rsp_exc` out 2: 00 ok, 01 illegal SPR, 10 privilege violation.
- `spr_wr` out 1: SPR file write enable.
- `spr_waddr` out `SPR_DEPTH`: decoded SPR number for the write.
- `spr_wd` out `SPR_WIDTH`: write data.
- `spr_raddr` out `SPR_DEPTH`: decoded SPR number for the read.
- `spr_rd` in `SPR_WIDTH`: combinational read data from the SPR file.
- `exc_cnt` out 8: saturating count of requests that completed with a nonzero `rsp_exc`.

## Operation
- **Decode.** n = {f[4:0], f[9:5]}.
- **Legal set.** n ∈ {1 XER, 8 LR, 9 CTR, 22 DEC, 26 SRR0, 27 SRR1, 272–275 SPRG0–3, 287 PVR}.
  - Low 5 bits of the legal set are unique, so the file's 32-entry index never aliases.
- **Exception priority**, highest first:
  - Not in the legal set → 01.
  - mtspr to 287 (PVR, read-only) → 01.
  - n[4]=1 and `req_pr`=1 → 10.
  - Otherwise → 00.
- **FSM states.** IDLE, EXEC, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, latch wr, n, wdata, tag and exc; go to EXEC.
  - EXEC (exactly 1 cycle):
    - `spr_raddr`=n; capture `spr_rd` into `rsp_rdata`.
    - `spr_wr` = wr & (exc==00), with `spr_waddr`=n and `spr_wd`=wdata.
    - If exc≠00, `rsp_rdata` is forced to 0.
    - Go to RESP.
  - RESP: `rsp_valid`=1; outputs are held stable until `rsp_ready`.
    - On `rsp_ready`: increment `exc_cnt` if exc≠00 (saturate at 255).
    - Then, if `req_valid`, accept the new request and go to EXEC (back-to-back); else go to IDLE.
- **`req_ready`** = (state==IDLE) | (state==RESP & `rsp_ready`). It is 0 while `rst`=1.
- **mtspr read data.** An mtspr response's `rsp_rdata` is the pre-write value: the read is combinational and the write lands at the end of EXEC.
- **Out-of-EXEC outputs.** `spr_wr`=0 in every state other than EXEC. `spr_raddr`/`spr_waddr` hold their last value outside EXEC.
- **Reset** (synchronous, any state):
  - State → IDLE.
  - `rsp_valid`, `spr_wr`, `rsp_rdata`, `rsp_tag`, `rsp_exc`, `spr_waddr`, `spr_raddr`, `spr_wd` → 0.
  - `exc_cnt` → 0.
  - A request in EXEC during reset does not write: `spr_wr` is forced to 0 in that cycle.
  - A pending response is dropped.

## Timing
- Request accepted at edge T → EXEC in cycle T+1 (SPR write commits at edge T+2) → `rsp_valid` high in cycle T+2.
- Back-to-back throughput: one request per 2 cycles when `rsp_ready` is held high.
- `rsp_*` are registered and stable from the rising edge of `rsp_valid` until the handshake.
- A read issued immediately after a write to the same n observes the new value (its EXEC follows the write edge).
- The handshake completes on any edge with valid & ready both high. No combinational path from `rsp_ready` to `rsp_valid`; only `req_ready` depends on `rsp_ready`.

## Test plan
- **Write LR then read LR:**
  - Stimulus: mtspr f=0x100 (n=8), wdata 0xDEADBEEF, tag 3, then mfspr n=8.
  - Response: first response rdata=0 (reset value), exc 00, tag 3; second response rdata 0xDEADBEEF; `spr_wr` pulses exactly one cycle.
- **Privilege and illegal checks:**
  - mfspr SRR0 (f=0x340, n=26) with `req_pr`=1 → exc 10, rdata 0, no write.
  - mtspr n=5 → exc 01.
  - mtspr PVR n=287 → exc 01; `exc_cnt`=3 after the three.
- **Response backpressure:** hold `rsp_ready`=0 for 5 cycles → `rsp_*` stable and `req_ready`=0 throughout. Then a single cycle with `rsp_ready`=1 and `req_valid`=1 → next request enters EXEC on the following cycle.
- **Reset mid-operation:** assert `rst` during EXEC of mtspr CTR=0x1234 → no write; subsequent mfspr CTR returns 0; all outputs 0 during reset.
- **Counter saturation:** issue 260 illegal requests → `exc_cnt` holds 255.
